wash_sequencer: RTL and testbench

WASH_SEQUENCER -- requirements
Module: wash_sequencer

---
 rtl/wash_sequencer_pkg.sv | 86 ++++++++
 rtl/wash_sequencer_phase_select.sv | 26 ++
 rtl/wash_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_wash_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/wash_sequencer_pkg.sv
// Shared definitions for the wash sequencer: state codes, phase indices,
// program masks and the per-phase duration table.
package wash_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_SHUTDOWN = 3'd0,
    ST_BEGIN    = 3'd1,
    ST_SET      = 3'd2,
    ST_RUN      = 3'd3,
    ST_ERROR    = 3'd4,
    ST_PAUSE    = 3'd5,
    ST_FINISH   = 3'd6
  } stateT;

  localparam logic [2:0] PH_FILL1  = 3'd0;
  localparam logic [2:0] PH_WASH   = 3'd1;
  localparam logic [2:0] PH_DRAIN1 = 3'd2;
  localparam logic [2:0] PH_SPIN1  = 3'd3;
  localparam logic [2:0] PH_FILL2  = 3'd4;
  localparam logic [2:0] PH_RINSE  = 3'd5;
  localparam logic [2:0] PH_DRAIN2 = 3'd6;
  localparam logic [2:0] PH_SPIN2  = 3'd7;

  localparam logic [7:0] PROG_P0 = 8'hFF;
  localparam logic [7:0] PROG_P1 = 8'hF0;
  localparam logic [7:0] PROG_P2 = 8'h0F;
  localparam logic [7:0] PROG_P3 = 8'h01;

  typedef logic [7:0][5:0] durTableT;

  function automatic durTableT buildDurTable(input int tIn, input int tWash,
                                             input int tOut, input int tSpin,
                                             input int tRinse);
    durTableT t;
    t[PH_FILL1]  = 6'(tIn);
    t[PH_WASH]   = 6'(tWash);
    t[PH_DRAIN1] = 6'(tOut);
    t[PH_SPIN1]  = 6'(tSpin);
    t[PH_FILL2]  = 6'(tIn);
    t[PH_RINSE]  = 6'(tRinse);
    t[PH_DRAIN2] = 6'(tOut);
    t[PH_SPIN2]  = 6'(tSpin);
    return t;
  endfunction

  localparam durTableT DEFAULT_DURS = buildDurTable(3, 9, 3, 3, 6);

  // Mask bit 7 corresponds to phase 0.
  function automatic logic [7:0] phaseBit(input logic [2:0] idx);
    return 8'h80 >> idx;
  endfunction

  function automatic logic [7:0] maskTotal(input logic [7:0] mask, input durTableT durs);
    logic [7:0] sum;
    sum = 8'd0;
    for (int i = 0; i < 8; i++) begin
      if (mask[3'(7 - i)]) begin
        sum = sum + {2'b00, durs[3'(i)]};
      end else begin
        sum = sum;
      end
    end
    return sum;
  endfunction

  function automatic logic [7:0] nextProgram(input logic [7:0] mask);
    logic [7:0] nxt;
    case (mask)
      PROG_P0: nxt = PROG_P1;
      PROG_P1: nxt = PROG_P2;
      PROG_P2: nxt = PROG_P3;
      default: nxt = PROG_P0;
    endcase
    return nxt;
  endfunction

  function automatic logic [9:0] dataWord(input stateT st, input logic [7:0] mask);
    logic showMask;
    case (st)
      ST_SET, ST_RUN, ST_PAUSE, ST_ERROR: showMask = 1'b1;
      default:                            showMask = 1'b0;
    endcase
    return {st == ST_SET, st != ST_SHUTDOWN, showMask ? mask : 8'h00};
  endfunction

endpackage

// File: rtl/wash_sequencer_phase_select.sv
// Finds the lowest-numbered set phase at or after startIdx in a phase mask.
module wash_sequencer_phase_select
  import wash_sequencer_pkg::*;
(
  input  logic [7:0] mask,
  input  logic [2:0] startIdx,
  output logic [2:0] idx,
  output logic       valid
);

  // Descending scan so the lowest qualifying phase is the one left standing.
  always_comb begin
    idx   = 3'd0;
    valid = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if ((i >= int'(startIdx)) && mask[3'(7 - i)]) begin
        idx   = 3'(i);
        valid = 1'b1;
      end else begin
        idx   = idx;
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/wash_sequencer.sv
// Washing-machine program sequencer: power-up dwell, program selection,
// timed phase execution with pause/lid fault handling, and finish dwell.
module wash_sequencer
  import wash_sequencer_pkg::*;
#(
  parameter int T_IN     = 3,
  parameter int T_WASH   = 9,
  parameter int T_OUT    = 3,
  parameter int T_SPIN   = 3,
  parameter int T_RINSE  = 6,
  parameter int BEGIN_S  = 2,
  parameter int FINISH_S = 5
) (
  input  logic       cp,
  input  logic       rst_n,
  input  logic       tick_1s,
  input  logic       power_btn,
  input  logic       start_btn,
  input  logic       mode_btn,
  input  logic       lid_open,
  output logic [2:0] state,
  output logic [9:0] data,
  output logic [2:0] shinning,
  output logic [5:0] phase_remain,
  output logic [7:0] total_remain,
  output logic       click
);

  localparam durTableT   DURS        = buildDurTable(T_IN, T_WASH, T_OUT, T_SPIN, T_RINSE);
  localparam logic [7:0] BEGIN_LAST  = 8'(BEGIN_S - 1);
  localparam logic [7:0] FINISH_LAST = 8'(FINISH_S - 1);

  stateT      stateR, nState;
  logic [7:0] maskR, nMask;
  logic [2:0] shinR, nShin;
  logic [5:0] phaseR, nPhase;
  logic [7:0] totalR, nTotal;
  logic [7:0] dwellR, nDwell;
  logic       clickR, nClick;
  logic [9:0] dataR;

  logic [7:0] selMask;
  logic [2:0] selStart;
  logic [2:0] selIdx;
  logic       selValid;

  // In SET the search starts the program; in RUN it finds the successor once
  // the current phase's bit is dropped.
  assign selMask  = (stateR == ST_SET) ? maskR : (maskR & ~phaseBit(shinR));
  assign selStart = (stateR == ST_SET) ? 3'd0 : shinR;

  wash_sequencer_phase_select phaseSelect (
    .mask     (selMask),
    .startIdx (selStart),
    .idx      (selIdx),
    .valid    (selValid)
  );

  // Next-state logic; one event acts per cycle, highest priority first.
  always_comb begin
    nState = stateR;
    nMask  = maskR;
    nShin  = shinR;
    nPhase = phaseR;
    nTotal = totalR;
    nDwell = dwellR;
    nClick = 1'b0;
    if (power_btn) begin
      nClick = 1'b1;
      nMask  = 8'h00;
      nShin  = 3'd0;
      nPhase = 6'd0;
      nTotal = 8'd0;
      nDwell = 8'd0;
      if (stateR == ST_SHUTDOWN) begin
        nState = ST_BEGIN;
      end else begin
        nState = ST_SHUTDOWN;
      end
    end else begin
      case (stateR)
        ST_SHUTDOWN: nState = ST_SHUTDOWN;
        ST_BEGIN: begin
          if (tick_1s) begin
            if (dwellR >= BEGIN_LAST) begin
              nState = ST_SET;
              nDwell = 8'd0;
              nMask  = PROG_P0;
              nTotal = maskTotal(PROG_P0, DURS);
            end else begin
              nDwell = dwellR + 8'd1;
            end
          end else begin
            nDwell = dwellR;
          end
        end
        ST_SET: begin
          if (start_btn) begin
            nClick = 1'b1;
            if (selValid) begin
              nState = ST_RUN;
              nShin  = selIdx;
              nPhase = DURS[selIdx];
            end else begin
              nState = ST_FINISH;
              nMask  = 8'h00;
              nTotal = 8'd0;
            end
          end else if (mode_btn) begin
            nClick = 1'b1;
            nMask  = nextProgram(maskR);
            nTotal = maskTotal(nextProgram(maskR), DURS);
          end else begin
            nState = ST_SET;
          end
        end
        ST_RUN: begin
          if (lid_open) begin
            nState = ST_ERROR;
          end else if (start_btn) begin
            nState = ST_PAUSE;
            nClick = 1'b1;
          end else if (tick_1s) begin
            if (phaseR <= 6'd1) begin
              nMask = selMask;
              if (selValid) begin
                nShin  = selIdx;
                nPhase = DURS[selIdx];
                nTotal = totalR - 8'd1;
              end else begin
                nState = ST_FINISH;
                nPhase = 6'd0;
                nTotal = 8'd0;
                nDwell = 8'd0;
              end
            end else begin
              nPhase = phaseR - 6'd1;
              nTotal = totalR - 8'd1;
            end
          end else begin
            nState = ST_RUN;
          end
        end
        ST_PAUSE: begin
          if (lid_open) begin
            nState = ST_ERROR;
          end else if (start_btn) begin
            nState = ST_RUN;
            nClick = 1'b1;
          end else begin
            nState = ST_PAUSE;
          end
        end
        ST_ERROR: begin
          if (start_btn && !lid_open) begin
            nState = ST_RUN;
            nClick = 1'b1;
          end else begin
            nState = ST_ERROR;
          end
        end
        ST_FINISH: begin
          if (tick_1s) begin
            if (dwellR >= FINISH_LAST) begin
              nState = ST_SHUTDOWN;
              nDwell = 8'd0;
              nShin  = 3'd0;
            end else begin
              nDwell = dwellR + 8'd1;
            end
          end else begin
            nDwell = dwellR;
          end
        end
        default: begin
          nState = ST_SHUTDOWN;
          nMask  = 8'h00;
          nShin  = 3'd0;
          nPhase = 6'd0;
          nTotal = 8'd0;
          nDwell = 8'd0;
        end
      endcase
    end
  end

  // State and output registers; data is decoded from the next state so it
  // is registered alongside everything else.
  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      stateR <= ST_SHUTDOWN;
      maskR  <= 8'h00;
      shinR  <= 3'd0;
      phaseR <= 6'd0;
      totalR <= 8'd0;
      dwellR <= 8'd0;
      clickR <= 1'b0;
      dataR  <= 10'd0;
    end else begin
      stateR <= nState;
      maskR  <= nMask;
      shinR  <= nShin;
      phaseR <= nPhase;
      totalR <= nTotal;
      dwellR <= nDwell;
      clickR <= nClick;
      dataR  <= dataWord(nState, nMask);
    end
  end

  assign state        = stateR;
  assign data         = dataR;
  assign shinning     = shinR;
  assign phase_remain = phaseR;
  assign total_remain = totalR;
  assign click        = clickR;

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed vector table plus randomized run against a phase-queue model.
module tb_wash_sequencer;

  localparam int T_IN = 3, T_WASH = 9, T_OUT = 3, T_SPIN = 3, T_RINSE = 6;
  localparam int BEGIN_S = 2, FINISH_S = 5;

  logic cp = 1'b0, rst_n = 1'b0;
  logic tick_1s = 1'b0, power_btn = 1'b0, start_btn = 1'b0, mode_btn = 1'b0, lid_open = 1'b0;
  logic [2:0] state, shinning;
  logic [9:0] data;
  logic [5:0] phase_remain;
  logic [7:0] total_remain;
  logic click;

  int nCmp = 0, nBad = 0;

  wash_sequencer #(.T_IN(T_IN), .T_WASH(T_WASH), .T_OUT(T_OUT), .T_SPIN(T_SPIN),
                   .T_RINSE(T_RINSE), .BEGIN_S(BEGIN_S), .FINISH_S(FINISH_S)) dut (
    .cp(cp), .rst_n(rst_n), .tick_1s(tick_1s), .power_btn(power_btn), .start_btn(start_btn),
    .mode_btn(mode_btn), .lid_open(lid_open), .state(state), .data(data), .shinning(shinning),
    .phase_remain(phase_remain), .total_remain(total_remain), .click(click));

  always #5 cp = ~cp;

  typedef struct {
    bit p, s, m, t, l;
    int st, sh, ph, tot, dat, ck;
  } vecT;
  vecT vecs[$];

  function automatic vecT mk(bit p, bit s, bit m, bit t, bit l,
                             int st, int sh, int ph, int tot, int dat, int ck);
    vecT v;
    v.p = p; v.s = s; v.m = m; v.t = t; v.l = l;
    v.st = st; v.sh = sh; v.ph = ph; v.tot = tot; v.dat = dat; v.ck = ck;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkAll(input string tag, input int st, input int sh, input int ph,
                          input int tot, input int dat, input int ck);
    check({tag, ".state"}, 32'(state), st);
    check({tag, ".shinning"}, 32'(shinning), sh);
    check({tag, ".phase_remain"}, 32'(phase_remain), ph);
    check({tag, ".total_remain"}, 32'(total_remain), tot);
    check({tag, ".data"}, 32'(data), dat);
    check({tag, ".click"}, 32'(click), ck);
  endtask

  task automatic cyc(input bit p, input bit s, input bit m, input bit t, input bit l);
    @(negedge cp);
    power_btn = p; start_btn = s; mode_btn = m; tick_1s = t; lid_open = l;
    @(posedge cp);
    #1;
  endtask

  // ---------------- reference model: remaining phases as a queue ----------------
  int durs[8];
  int progFirst[4] = '{0, 0, 4, 7};
  int progLast[4]  = '{7, 3, 7, 7};
  int mState, mShin, mElapsed, mDwell, mProg, mClick;
  int mQ[$];

  function automatic void modelReset();
    mState = 0; mShin = 0; mElapsed = 0; mDwell = 0; mProg = 0; mClick = 0;
    mQ.delete();
  endfunction

  function automatic void loadProg(int pg);
    mProg = pg;
    mQ.delete();
    for (int i = progFirst[pg]; i <= progLast[pg]; i++) mQ.push_back(i);
  endfunction

  function automatic void modelStep(bit p, bit s, bit m, bit t, bit l);
    mClick = 0;
    if (p) begin
      mClick = 1;
      if (mState == 0) begin
        mState = 1; mDwell = 0;
      end else begin
        modelReset(); mClick = 1;
      end
    end else begin
      case (mState)
        1: if (t) begin
             mDwell++;
             if (mDwell == BEGIN_S) begin mState = 2; mDwell = 0; mElapsed = 0; loadProg(0); end
           end
        2: if (s) begin mState = 3; mClick = 1; mShin = mQ[0]; mElapsed = 0; end
           else if (m) begin mClick = 1; loadProg((mProg + 1) % 4); end
        3: if (l) mState = 4;
           else if (s) begin mState = 5; mClick = 1; end
           else if (t) begin
             mElapsed++;
             if (mElapsed == durs[mQ[0]]) begin
               void'(mQ.pop_front());
               mElapsed = 0;
               if (mQ.size() == 0) begin mState = 6; mDwell = 0; end
               else mShin = mQ[0];
             end
           end
        5: if (l) mState = 4;
           else if (s) begin mState = 3; mClick = 1; end
        4: if (s && !l) begin mState = 3; mClick = 1; end
        6: if (t) begin
             mDwell++;
             if (mDwell == FINISH_S) begin mState = 0; mDwell = 0; mShin = 0; end
           end
        default: ;
      endcase
    end
  endfunction

  task automatic compareModel(input string tag);
    int mask, tot, ph, dat;
    mask = 0; tot = 0;
    foreach (mQ[i]) begin
      mask |= (8'h80 >> mQ[i]);
      tot += durs[mQ[i]];
    end
    tot -= mElapsed;
    ph = (mState == 3 || mState == 4 || mState == 5) ? durs[mQ[0]] - mElapsed : 0;
    dat = ((mState == 2) ? 'h200 : 0) | ((mState != 0) ? 'h100 : 0) |
          ((mState >= 2 && mState <= 5) ? mask : 0);
    checkAll(tag, mState, mShin, ph, tot, dat, mClick);
  endtask

  initial begin
    bit p, s, m, t, l;
    int sel;
    durs = '{T_IN, T_WASH, T_OUT, T_SPIN, T_IN, T_RINSE, T_OUT, T_SPIN};

    // p s m t l | state shin phase total data click
    vecs.push_back(mk(1,0,0,0,0, 1,0,0,0,'h100,1));   // power on
    vecs.push_back(mk(0,0,0,1,0, 1,0,0,0,'h100,0));
    vecs.push_back(mk(0,0,0,1,0, 2,0,0,33,'h3FF,0));  // SET, P0
    vecs.push_back(mk(0,1,0,0,0, 3,0,3,33,'h1FF,1));  // start
    vecs.push_back(mk(0,0,0,1,0, 3,0,2,32,'h1FF,0));
    vecs.push_back(mk(0,1,0,1,0, 5,0,2,32,'h1FF,1));  // start+tick -> PAUSE, no decrement
    vecs.push_back(mk(0,0,0,1,0, 5,0,2,32,'h1FF,0));
    vecs.push_back(mk(0,1,0,0,0, 3,0,2,32,'h1FF,1));
    vecs.push_back(mk(0,0,1,0,0, 3,0,2,32,'h1FF,0));  // mode ignored in RUN
    vecs.push_back(mk(0,0,0,1,0, 3,0,1,31,'h1FF,0));
    vecs.push_back(mk(0,0,0,1,0, 3,1,9,30,'h17F,0));  // phase 0 done
    vecs.push_back(mk(0,0,0,0,1, 4,1,9,30,'h17F,0));  // lid -> ERROR
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0,0,0,1,1, 4,1,9,30,'h17F,0));
    vecs.push_back(mk(0,1,0,0,1, 4,1,9,30,'h17F,0));  // start with lid open ignored
    vecs.push_back(mk(0,1,0,0,0, 3,1,9,30,'h17F,1));
    vecs.push_back(mk(0,0,0,1,0, 3,1,8,29,'h17F,0));
    vecs.push_back(mk(1,0,0,0,0, 0,0,0,0,0,1));       // power mid-RUN
    vecs.push_back(mk(1,0,0,0,0, 1,0,0,0,'h100,1));   // P1 run
    vecs.push_back(mk(0,0,0,1,0, 1,0,0,0,'h100,0));
    vecs.push_back(mk(0,0,0,1,0, 2,0,0,33,'h3FF,0));
    vecs.push_back(mk(0,0,1,0,0, 2,0,0,18,'h3F0,1));
    vecs.push_back(mk(0,1,0,0,0, 3,0,3,18,'h1F0,1));
    vecs.push_back(mk(0,0,0,1,0, 3,0,2,17,'h1F0,0));
    vecs.push_back(mk(0,0,0,1,0, 3,0,1,16,'h1F0,0));
    vecs.push_back(mk(0,0,0,1,0, 3,1,9,15,'h170,0));
    vecs.push_back(mk(1,0,0,0,0, 0,0,0,0,0,1));
    vecs.push_back(mk(1,0,0,0,0, 1,0,0,0,'h100,1));   // P3 run
    vecs.push_back(mk(0,0,0,1,0, 1,0,0,0,'h100,0));
    vecs.push_back(mk(0,0,0,1,0, 2,0,0,33,'h3FF,0));
    vecs.push_back(mk(0,0,1,0,0, 2,0,0,18,'h3F0,1));
    vecs.push_back(mk(0,0,1,0,0, 2,0,0,15,'h30F,1));
    vecs.push_back(mk(0,0,1,0,0, 2,0,0,3,'h301,1));
    vecs.push_back(mk(0,1,0,0,0, 3,7,3,3,'h101,1));
    vecs.push_back(mk(0,0,0,1,0, 3,7,2,2,'h101,0));
    vecs.push_back(mk(0,0,0,1,0, 3,7,1,1,'h101,0));
    vecs.push_back(mk(0,0,0,1,0, 6,7,0,0,'h100,0));   // FINISH
    vecs.push_back(mk(0,1,0,0,0, 6,7,0,0,'h100,0));   // start ignored in FINISH
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0,0,0,1,0, 6,7,0,0,'h100,0));
    vecs.push_back(mk(0,0,0,1,0, 0,0,0,0,0,0));       // SHUTDOWN
    vecs.push_back(mk(0,1,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(0,0,1,0,0, 0,0,0,0,0,0));

    repeat (3) @(posedge cp);
    #1;
    checkAll("reset", 0, 0, 0, 0, 0, 0);
    @(negedge cp);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      cyc(vecs[i].p, vecs[i].s, vecs[i].m, vecs[i].t, vecs[i].l);
      checkAll($sformatf("vec%0d", i), vecs[i].st, vecs[i].sh, vecs[i].ph,
               vecs[i].tot, vecs[i].dat, vecs[i].ck);
    end

    // Asynchronous reset mid-RUN must clear outputs before any clock edge.
    cyc(1,0,0,0,0); cyc(0,0,0,1,0); cyc(0,0,0,1,0); cyc(0,1,0,0,0); cyc(0,0,0,1,0);
    checkAll("preRst", 3, 0, 2, 32, 'h1FF, 0);
    @(negedge cp);
    power_btn = 1'b0; start_btn = 1'b0; mode_btn = 1'b0; tick_1s = 1'b0; lid_open = 1'b0;
    #2 rst_n = 1'b0;
    #1 checkAll("asyncRst", 0, 0, 0, 0, 0, 0);
    @(negedge cp);
    rst_n = 1'b1;
    cyc(0,0,0,1,0);
    checkAll("postRst", 0, 0, 0, 0, 0, 0);

    // Randomized run against the model.
    modelReset();
    l = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      sel = $urandom_range(0, 99);
      p = (mState == 0) ? (sel < 25) : (sel < 1);
      s = !p && sel >= 40 && sel < 48;
      m = !p && sel >= 60 && sel < 66;
      t = ($urandom_range(0, 2) == 0);
      if (mState == 3 || mState == 4 || mState == 5) begin
        if ($urandom_range(0, 29) == 0) l = !l;
      end else begin
        l = 1'b0;
      end
      modelStep(p, s, m, t, l);
      cyc(p, s, m, t, l);
      compareModel($sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
